// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the dual-core ALU arbiter: FSM state encodings and
// the ALU control codes understood by the shared alu.
package alu_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin selector. Purely combinational: the caller owns the
// last_grant register and feeds it back in.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant,
    output logic       gnt_id
);

    // Lone requester wins; on contention the core not served last time wins.
    always_comb begin
        if (req == 2'b11) begin
            gnt_id = ~last_grant;
        end else begin
            gnt_id = req[1];
        end
        if (req == 2'b00) begin
            grant = 2'b00;
        end else if (gnt_id) begin
            grant = 2'b10;
        end else begin
            grant = 2'b01;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one WIDTH-bit ALU between two cores. One operation is accepted in
// IDLE, executed on the registered alu inputs in EXEC and returned as a
// one-cycle response pulse in RESP.
// Optional build macro: ALU_ARB_STATS_EN adds per-core 16-bit grant counters.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_alucont,
    output logic             rsp0_valid,
    output logic [WIDTH-1:0] rsp0_result,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_alucont,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp1_result,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_alucont,
    input  logic [WIDTH-1:0] alu_result
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0]      grant_cnt0,
    output logic [15:0]      grant_cnt1
`endif
);

    state_t           state_reg;
    state_t           state_next;
    logic             last_grant_reg;
    logic             cur_grant_reg;
    logic [1:0]       req_valid_vec;
    logic [1:0]       rr_grant;
    logic             rr_gnt_id;
    logic             accept;
    logic [1:0]       ready_vec;
    logic [1:0]       rsp_valid_vec;
    logic [WIDTH-1:0] req_a_vec [2];
    logic [WIDTH-1:0] req_b_vec [2];
    logic [2:0]       req_c_vec [2];
    logic [WIDTH-1:0] rsp_result_reg [2];

    assign req_valid_vec = {req1_valid, req0_valid};
    assign req_a_vec[0]  = req0_a;
    assign req_a_vec[1]  = req1_a;
    assign req_b_vec[0]  = req0_b;
    assign req_b_vec[1]  = req1_b;
    assign req_c_vec[0]  = req0_alucont;
    assign req_c_vec[1]  = req1_alucont;

    rr_arb2 u_rr (
        .req        (req_valid_vec),
        .last_grant (last_grant_reg),
        .grant      (rr_grant),
        .gnt_id     (rr_gnt_id)
    );

    assign accept = (state_reg == S_IDLE) && (req_valid_vec != 2'b00);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: fixed IDLE -> EXEC -> RESP -> IDLE loop, leaving IDLE only on a handshake.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (accept) state_next = S_EXEC;
            S_EXEC:  state_next = S_RESP;
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs: ready only in IDLE for the winner, response pulse only in RESP.
    always_comb begin
        ready_vec     = 2'b00;
        rsp_valid_vec = 2'b00;
        if (state_reg == S_IDLE) begin
            ready_vec = rr_grant;
        end
        if (state_reg == S_RESP) begin
            rsp_valid_vec[cur_grant_reg] = 1'b1;
        end
    end

    assign req0_ready  = ready_vec[0];
    assign req1_ready  = ready_vec[1];
    assign rsp0_valid  = rsp_valid_vec[0];
    assign rsp1_valid  = rsp_valid_vec[1];
    assign rsp0_result = rsp_result_reg[0];
    assign rsp1_result = rsp_result_reg[1];

    // Operand latch and grant bookkeeping; last_grant moves only once the response is out.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_a          <= '0;
            alu_b          <= '0;
            alu_alucont    <= '0;
            cur_grant_reg  <= 1'b0;
            last_grant_reg <= 1'b1;
        end else begin
            if (accept) begin
                alu_a         <= req_a_vec[rr_gnt_id];
                alu_b         <= req_b_vec[rr_gnt_id];
                alu_alucont   <= req_c_vec[rr_gnt_id];
                cur_grant_reg <= rr_gnt_id;
            end
            if (state_reg == S_RESP) begin
                last_grant_reg <= cur_grant_reg;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_core
            // Per-core result register: captured in EXEC, held until that core's next response.
            always_ff @(posedge clk) begin
                if (reset) begin
                    rsp_result_reg[gi] <= '0;
                end else if (state_reg == S_EXEC && cur_grant_reg == 1'(gi)) begin
                    rsp_result_reg[gi] <= alu_result;
                end
            end
        end
    endgenerate

`ifdef ALU_ARB_STATS_EN
    logic [15:0] grant_cnt_reg [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_stats
            // Count accepted handshakes per core; wraps naturally at 2^16.
            always_ff @(posedge clk) begin
                if (reset) begin
                    grant_cnt_reg[gi] <= '0;
                end else if (ready_vec[gi]) begin
                    grant_cnt_reg[gi] <= grant_cnt_reg[gi] + 16'd1;
                end
            end
        end
    endgenerate

    assign grant_cnt0 = grant_cnt_reg[0];
    assign grant_cnt1 = grant_cnt_reg[1];
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a transaction-level model (busy window,
// pending-response queue, held results) checked every cycle, plus directed
// sequences with hand-computed literal expectations and a randomized phase.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0] req0_alucont, req1_alucont;
    logic       rsp0_valid, rsp1_valid;
    logic [7:0] rsp0_result, rsp1_result;
    logic [7:0] alu_a, alu_b, alu_result;
    logic [2:0] alu_alucont;
`ifdef ALU_ARB_STATS_EN
    logic [15:0] grant_cnt0, grant_cnt1;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req0_alucont (req0_alucont),
        .rsp0_valid   (rsp0_valid),
        .rsp0_result  (rsp0_result),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .req1_alucont (req1_alucont),
        .rsp1_valid   (rsp1_valid),
        .rsp1_result  (rsp1_result),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_alucont  (alu_alucont),
        .alu_result   (alu_result)
`ifdef ALU_ARB_STATS_EN
        ,
        .grant_cnt0   (grant_cnt0),
        .grant_cnt1   (grant_cnt1)
`endif
    );

    // The shared external alu.
    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [2:0] c);
        case (c)
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_SLT: return ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
            default: return a ^ b;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_a, alu_b, alu_alucont);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    typedef struct {
        int         t;
        bit         core;
        logic [7:0] res;
    } exp_t;

    exp_t        pend[$];
    int          cyc     = 0;
    int          free_at = 0;
    bit          last    = 1'b1;
    logic [7:0]  held [2];
    logic [15:0] cnt  [2];

    // Per-cycle compare against the model, then advance the model.
    always @(negedge clk) begin
        bit         win;
        bit         any;
        logic [1:0] exp_rdy;
        logic [1:0] exp_rsp;
        if (reset) begin
            pend.delete();
            free_at = cyc + 1;
            last    = 1'b1;
            held[0] = 8'h00;
            held[1] = 8'h00;
            cnt[0]  = 16'h0;
            cnt[1]  = 16'h0;
        end else begin
            any = 1'b0;
            win = 1'b0;
            if (cyc >= free_at && (req0_valid || req1_valid)) begin
                any = 1'b1;
                if (req0_valid && req1_valid) win = !last;
                else                          win = req1_valid;
            end
            exp_rdy = 2'b00;
            if (any) exp_rdy[win] = 1'b1;
            chk("ready0", req0_ready, exp_rdy[0]);
            chk("ready1", req1_ready, exp_rdy[1]);

            exp_rsp = 2'b00;
            if (pend.size() > 0 && pend[0].t == cyc) begin
                exp_rsp[pend[0].core] = 1'b1;
                held[pend[0].core]    = pend[0].res;
                void'(pend.pop_front());
            end
            chk("rsp0_valid", rsp0_valid, exp_rsp[0]);
            chk("rsp1_valid", rsp1_valid, exp_rsp[1]);
            chk("rsp0_result", rsp0_result, held[0]);
            chk("rsp1_result", rsp1_result, held[1]);

            if (any) begin
                if (win) pend.push_back('{cyc + 2, 1'b1, alu_fn(req1_a, req1_b, req1_alucont)});
                else     pend.push_back('{cyc + 2, 1'b0, alu_fn(req0_a, req0_b, req0_alucont)});
                free_at = cyc + 3;
                last    = win;
                cnt[win] = cnt[win] + 16'd1;
            end
`ifdef ALU_ARB_STATS_EN
            chk("grant_cnt0", grant_cnt0, cnt[0]);
            chk("grant_cnt1", grant_cnt1, cnt[1]);
`endif
        end
        cyc++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit core, input bit v, input logic [7:0] a, input logic [7:0] b, input logic [2:0] c);
        if (core) begin
            req1_valid = v; req1_a = a; req1_b = b; req1_alucont = c;
        end else begin
            req0_valid = v; req0_a = a; req0_b = b; req0_alucont = c;
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // Single operation with literal expected result; must be taken immediately and answer 2 cycles later.
    task automatic issue(input bit core, input logic [7:0] a, input logic [7:0] b, input logic [2:0] c,
                         input logic [7:0] exp, input string nm);
        int n = 0;
        set_req(core, 1'b1, a, b, c);
        @(negedge clk);
        while (!(core ? req1_ready : req0_ready) && n < 20) begin
            tick();
            @(negedge clk);
            n++;
        end
        chk({nm, "_hs_wait"}, n, 0);
        tick();
        set_req(core, 1'b0, a, b, c);
        @(negedge clk);
        chk({nm, "_exec_novalid"}, core ? rsp1_valid : rsp0_valid, 1'b0);
        tick();
        @(negedge clk);
        chk({nm, "_rsp_valid"}, core ? rsp1_valid : rsp0_valid, 1'b1);
        chk({nm, "_result"}, core ? rsp1_result : rsp0_result, exp);
        chk({nm, "_other_valid"}, core ? rsp0_valid : rsp1_valid, 1'b0);
        tick();
    endtask

    initial begin
        int order[$];
        reset = 1'b1;
        set_req(1'b0, 1'b0, 8'h00, 8'h00, 3'b000);
        set_req(1'b1, 1'b0, 8'h00, 8'h00, 3'b000);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state.
        @(negedge clk);
        chk("rst_alu_a", alu_a, 8'h00);
        chk("rst_alu_b", alu_b, 8'h00);
        chk("rst_alucont", alu_alucont, 3'b000);
        chk("rst_rsp0_result", rsp0_result, 8'h00);
        chk("rst_rsp1_result", rsp1_result, 8'h00);
        chk("rst_rsp0_valid", rsp0_valid, 1'b0);
        tick();

        // Single request: 5 + 3 = 8.
        issue(1'b0, 8'd5, 8'd3, ALU_ADD, 8'd8, "single_add");

        // Contention right after reset: core0 SUB 7-9 first, core1 AND F0&3C second.
        do_reset();
        set_req(1'b0, 1'b1, 8'd7, 8'd9, ALU_SUB);
        set_req(1'b1, 1'b1, 8'hF0, 8'h3C, ALU_AND);
        @(negedge clk);
        chk("cont_c0_ready0", req0_ready, 1'b1);
        chk("cont_c0_ready1", req1_ready, 1'b0);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("cont_c1_ready1", req1_ready, 1'b0);
        tick();
        @(negedge clk);
        chk("cont_c2_rsp0_valid", rsp0_valid, 1'b1);
        chk("cont_c2_rsp0_result", rsp0_result, 8'hFE);
        chk("cont_c2_ready1", req1_ready, 1'b0);
        tick();
        @(negedge clk);
        chk("cont_c3_ready1", req1_ready, 1'b1);
        tick();
        req1_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("cont_c5_rsp1_valid", rsp1_valid, 1'b1);
        chk("cont_c5_rsp1_result", rsp1_result, 8'h30);
        tick();

        // Sustained contention: grant order 0,1,0,1.
        do_reset();
        set_req(1'b0, 1'b1, 8'd10, 8'd20, ALU_ADD);
        set_req(1'b1, 1'b1, 8'h55, 8'h0F, ALU_OR);
        for (int k = 0; k < 16 && order.size() < 4; k++) begin
            @(negedge clk);
            if (req0_ready) order.push_back(0);
            else if (req1_ready) order.push_back(1);
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("sust_grants", order.size(), 4);
        for (int i = 0; i < order.size(); i++) chk($sformatf("sust_order%0d", i), order[i], i % 2);
        repeat (2) tick();

        // SLT on core 1.
        issue(1'b1, 8'd2, 8'd9, ALU_SLT, 8'd1, "slt_lt");
        issue(1'b1, 8'd9, 8'd2, ALU_SLT, 8'd0, "slt_ge");

        // Reset in EXEC: core0 served last, then core1 op aborted; next contention goes to core 0.
        issue(1'b0, 8'd1, 8'd1, ALU_ADD, 8'd2, "pre_abort");
        set_req(1'b1, 1'b1, 8'd4, 8'd4, ALU_ADD);
        @(negedge clk);
        chk("abort_hs1", req1_ready, 1'b1);
        tick();
        req1_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_req(1'b0, 1'b1, 8'd6, 8'd6, ALU_OR);
        set_req(1'b1, 1'b1, 8'd6, 8'd6, ALU_AND);
        @(negedge clk);
        chk("abort_next_ready0", req0_ready, 1'b1);
        chk("abort_next_ready1", req1_ready, 1'b0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("abort_no_rsp1", rsp1_valid, 1'b0);
            tick();
        end

`ifdef ALU_ARB_STATS_EN
        // Grant counters: 3 core-0 and 2 core-1 operations after reset.
        do_reset();
        for (int k = 0; k < 3; k++) issue(1'b0, 8'(k), 8'd1, ALU_ADD, 8'(k + 1), "stat0");
        for (int k = 0; k < 2; k++) issue(1'b1, 8'(k), 8'd3, ALU_OR, 8'(k) | 8'd3, "stat1");
        @(negedge clk);
        chk("stats_cnt0", grant_cnt0, 16'd3);
        chk("stats_cnt1", grant_cnt1, 16'd2);
        tick();
`endif

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 3000; k++) begin
            logic [2:0] ops [5];
            ops = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT};
            reset = ($urandom_range(0, 149) == 0);
            set_req(1'b0, !reset && ($urandom_range(0, 9) < 6), 8'($urandom), 8'($urandom), ops[$urandom_range(0, 4)]);
            set_req(1'b1, !reset && ($urandom_range(0, 9) < 6), 8'($urandom), 8'($urandom), ops[$urandom_range(0, 4)]);
            tick();
        end
        reset = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (4) tick();

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
